// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control stage: funct3 codes, memory
// length encodings, FSM states and request decode helpers.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_BYTE   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    function automatic logic lsu_illegal(input logic wr, input logic [2:0] f3);
        if (wr) begin
            return !(f3 inside {SB, SH, SW});
        end
        return !(f3 inside {LB, LH, LW, LBU, LHU});
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] len, input logic [1:0] lo);
        case (len)
            LEN_H:   return lo[0];
            LEN_W:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_merge.sv
// Inserts one load byte into its lane of the partially assembled word and
// extends the result to XLEN according to the access length.
module lsu_byte_merge
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] acc,
    input  logic [7:0]      lane_byte,
    input  logic [1:0]      lane,
    input  logic [1:0]      len,
    input  logic            sign_ext,
    output logic [XLEN-1:0] merged_c,
    output logic [XLEN-1:0] result_c
);

    always_comb begin
        merged_c = acc;
        merged_c[{lane, 3'b000} +: 8] = lane_byte;
    end

    always_comb begin
        result_c = merged_c;
        case (len)
            LEN_B:   result_c = {{24{sign_ext & merged_c[7]}}, merged_c[7:0]};
            LEN_H:   result_c = {{16{sign_ext & merged_c[15]}}, merged_c[15:0]};
            default: result_c = merged_c;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the byte-addressed data memory; splits
// misaligned half/word accesses into sequential byte accesses.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [1:0]      mem_length,
    output logic            mem_sign,
    output logic            mem_enable,
    output logic            mem_wr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state;
    logic            wr_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] acc_q;
    logic [1:0]      k_q;
    logic [1:0]      k_last_q;

    logic            illegal_c;
    logic            misal_c;
    logic [1:0]      k_nxt_c;
    logic [XLEN-1:0] addr_nxt_c;
    logic [XLEN-1:0] merged_c;
    logic [XLEN-1:0] result_c;

    assign illegal_c  = lsu_illegal(req_wr, req_funct3);
    assign misal_c    = lsu_misaligned(req_funct3[1:0], req_addr[1:0]);
    assign k_nxt_c    = k_q + 2'd1;
    assign addr_nxt_c = addr_q + XLEN'(k_nxt_c);

    lsu_byte_merge u_merge (
        .acc       (acc_q),
        .lane_byte (mem_rdata[7:0]),
        .lane      (k_q),
        .len       (f3_q[1:0]),
        .sign_ext  (~f3_q[2]),
        .merged_c  (merged_c),
        .result_c  (result_c)
    );

    // Control FSM; every memory and response output is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            mem_addr   <= '0;
            mem_length <= LEN_B;
            mem_sign   <= 1'b0;
            mem_enable <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
            wr_q       <= 1'b0;
            f3_q       <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            acc_q      <= '0;
            k_q        <= 2'd0;
            k_last_q   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        wr_q      <= req_wr;
                        f3_q      <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        acc_q     <= '0;
                        k_q       <= 2'd0;
                        k_last_q  <= (req_funct3[1:0] == LEN_W) ? 2'd3 : 2'd1;
                        if (illegal_c || (misal_c && !SPLIT_MISALIGNED)) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (misal_c) begin
                            state      <= ST_BYTE;
                            mem_enable <= 1'b1;
                            mem_wr     <= req_wr;
                            mem_addr   <= req_addr;
                            mem_length <= LEN_B;
                            mem_sign   <= 1'b0;
                            mem_wdata  <= XLEN'(req_wdata[7:0]);
                        end else begin
                            state      <= ST_ACCESS;
                            mem_enable <= 1'b1;
                            mem_wr     <= req_wr;
                            mem_addr   <= req_addr;
                            mem_length <= req_funct3[1:0];
                            mem_sign   <= ~req_funct3[2];
                            mem_wdata  <= req_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_enable <= 1'b0;
                    mem_wr     <= 1'b0;
                    state      <= ST_RESP;
                    rsp_valid  <= 1'b1;
                    rsp_rdata  <= wr_q ? '0 : mem_rdata;
                end
                ST_BYTE: begin
                    acc_q <= merged_c;
                    if (k_q == k_last_q) begin
                        mem_enable <= 1'b0;
                        mem_wr     <= 1'b0;
                        state      <= ST_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= wr_q ? '0 : result_c;
                    end else begin
                        k_q       <= k_nxt_c;
                        mem_addr  <= addr_nxt_c;
                        mem_wdata <= XLEN'(wdata_q[{k_nxt_c, 3'b000} +: 8]);
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressed memory model; a second
// instance built without misaligned splitting shares the request stream.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [1:0]  mem_length;
    logic        mem_sign;
    logic        mem_enable;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        ns_req_ready;
    logic        ns_rsp_valid;
    logic [31:0] ns_rsp_rdata;
    logic        ns_rsp_err;
    logic [31:0] ns_mem_addr;
    logic [1:0]  ns_mem_length;
    logic        ns_mem_sign;
    logic        ns_mem_enable;
    logic        ns_mem_wr;
    logic [31:0] ns_mem_wdata;

    int total;
    int bad;

    logic [7:0]  mem [0:255];
    logic [7:0]  a0, a1, a2, a3;
    logic        pk_en;
    logic [7:0]  pk_addr;
    logic [7:0]  pk_data;
    int          en_cnt;
    int          ns_en_cnt;
    logic [1:0]  last_len;

    int          lat;
    int          ns_lat;
    logic        ns_err_seen;
    logic [31:0] got_rdata;
    logic        got_err;

    lsu_ctrl #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_length (mem_length),
        .mem_sign   (mem_sign),
        .mem_enable (mem_enable),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    lsu_ctrl #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (ns_req_ready),
        .req_wr     (req_wr),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (ns_rsp_valid),
        .rsp_rdata  (ns_rsp_rdata),
        .rsp_err    (ns_rsp_err),
        .mem_addr   (ns_mem_addr),
        .mem_length (ns_mem_length),
        .mem_sign   (ns_mem_sign),
        .mem_enable (ns_mem_enable),
        .mem_wr     (ns_mem_wr),
        .mem_wdata  (ns_mem_wdata),
        .mem_rdata  (32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational extended read, writes commit at negedge.
    assign a0 = mem_addr[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;

    always_comb begin
        case (mem_length)
            2'b00:   mem_rdata = {{24{mem_sign & mem[a0][7]}}, mem[a0]};
            2'b01:   mem_rdata = {{16{mem_sign & mem[a1][7]}}, mem[a1], mem[a0]};
            default: mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
        endcase
    end

    always @(negedge clk) begin
        if (pk_en) mem[pk_addr] <= pk_data;
        if (mem_enable) begin
            en_cnt   <= en_cnt + 1;
            last_len <= mem_length;
            if (mem_wr) begin
                mem[a0] <= mem_wdata[7:0];
                if (mem_length != 2'b00) mem[a1] <= mem_wdata[15:8];
                if (mem_length == 2'b10) begin
                    mem[a2] <= mem_wdata[23:16];
                    mem[a3] <= mem_wdata[31:24];
                end
            end
        end
        if (ns_mem_enable) ns_en_cnt <= ns_en_cnt + 1;
    end

    task automatic poke(input logic [7:0] addr, input logic [7:0] data);
        pk_addr = addr;
        pk_data = data;
        pk_en   = 1'b1;
        @(negedge clk);
        #1 pk_en = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(negedge clk);
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready: got %b want 1", req_ready);
        end
        total++;
        req_valid  = 1'b1;
        req_wr     = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        lat         = 0;
        ns_lat      = 0;
        ns_err_seen = 1'b0;
        got_rdata   = 32'hDEAD_BEEF;
        got_err     = 1'bx;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ns_rsp_valid && ns_lat == 0) begin
                ns_lat      = i;
                ns_err_seen = ns_rsp_err;
            end
            if (rsp_valid) begin
                lat       = i;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if ({req_ready, rsp_valid, rsp_err, mem_enable, mem_wr} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 10000",
                     {req_ready, rsp_valid, rsp_err, mem_enable, mem_wr});
        end
        total++;
        if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h want 0 0 0", rsp_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_aligned_lw();
        int e0;
        poke(8'h10, 8'h78);
        poke(8'h11, 8'h56);
        poke(8'h12, 8'h34);
        poke(8'h13, 8'h12);
        e0 = en_cnt;
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        wait_rsp();
        total++;
        if (lat !== 2) begin bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
        total++;
        if (got_rdata !== 32'h1234_5678) begin bad++; $display("FAIL lw_rdata: got %h want 12345678", got_rdata); end
        total++;
        if (en_cnt - e0 !== 1) begin bad++; $display("FAIL lw_enables: got %0d want 1", en_cnt - e0); end
        total++;
        if (last_len !== 2'b10) begin bad++; $display("FAIL lw_length: got %b want 10", last_len); end
    endtask

    task automatic test_lb_lbu();
        poke(8'h20, 8'h80);
        issue(1'b0, 3'd0, 32'h20, 32'h0);
        wait_rsp();
        total++;
        if (got_rdata !== 32'hFFFF_FF80 || lat !== 2) begin
            bad++; $display("FAIL lb_sext: got %h lat %0d want ffffff80 lat 2", got_rdata, lat);
        end
        issue(1'b0, 3'd4, 32'h20, 32'h0);
        wait_rsp();
        total++;
        if (got_rdata !== 32'h0000_0080) begin bad++; $display("FAIL lbu_zext: got %h want 00000080", got_rdata); end
    endtask

    task automatic test_misaligned_sw();
        int e0;
        for (int i = 0; i < 6; i++) poke(8'h20 + 8'(i), 8'h00);
        e0 = en_cnt;
        issue(1'b1, 3'd2, 32'h21, 32'hAABB_CCDD);
        wait_rsp();
        total++;
        if (lat !== 5) begin bad++; $display("FAIL sw_split_latency: got %0d want 5", lat); end
        total++;
        if (got_rdata !== 32'h0 || got_err !== 1'b0) begin
            bad++; $display("FAIL sw_split_rsp: got %h err %b want 0 err 0", got_rdata, got_err);
        end
        total++;
        if (en_cnt - e0 !== 4) begin bad++; $display("FAIL sw_split_enables: got %0d want 4", en_cnt - e0); end
        total++;
        if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24], mem[8'h25]} !== 48'h00DDCCBBAA00) begin
            bad++; $display("FAIL sw_split_bytes: got %h want 00ddccbbaa00",
                            {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24], mem[8'h25]});
        end
        issue(1'b0, 3'd2, 32'h20, 32'h0);
        wait_rsp();
        total++;
        if (got_rdata !== 32'hBBCC_DD00) begin bad++; $display("FAIL sw_followup_lw: got %h want bbccdd00", got_rdata); end
    endtask

    task automatic test_misaligned_lh();
        int ne0;
        poke(8'h33, 8'h01);
        poke(8'h34, 8'h90);
        ne0 = ns_en_cnt;
        issue(1'b0, 3'd1, 32'h33, 32'h0);
        wait_rsp();
        total++;
        if (got_rdata !== 32'hFFFF_9001 || lat !== 3) begin
            bad++; $display("FAIL lh_split: got %h lat %0d want ffff9001 lat 3", got_rdata, lat);
        end
        total++;
        if (ns_err_seen !== 1'b1 || ns_lat !== 1) begin
            bad++; $display("FAIL lh_nosplit_err: got err %b lat %0d want err 1 lat 1", ns_err_seen, ns_lat);
        end
        total++;
        if (ns_en_cnt - ne0 !== 0) begin bad++; $display("FAIL lh_nosplit_enable: got %0d want 0", ns_en_cnt - ne0); end
        issue(1'b0, 3'd5, 32'h33, 32'h0);
        wait_rsp();
        total++;
        if (got_rdata !== 32'h0000_9001) begin bad++; $display("FAIL lhu_split: got %h want 00009001", got_rdata); end
    endtask

    task automatic test_wrap();
        poke(8'hFF, 8'h34);
        poke(8'h00, 8'h82);
        issue(1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0);
        wait_rsp();
        total++;
        if (got_rdata !== 32'hFFFF_8234 || lat !== 3) begin
            bad++; $display("FAIL lh_wrap: got %h lat %0d want ffff8234 lat 3", got_rdata, lat);
        end
    endtask

    task automatic test_illegal();
        int e0;
        e0 = en_cnt;
        issue(1'b0, 3'd3, 32'h10, 32'h0);
        wait_rsp();
        total++;
        if (got_err !== 1'b1 || got_rdata !== 32'h0 || lat !== 1) begin
            bad++; $display("FAIL illegal_load: got err %b data %h lat %0d want 1 0 1", got_err, got_rdata, lat);
        end
        issue(1'b1, 3'd4, 32'h10, 32'hFFFF_FFFF);
        wait_rsp();
        total++;
        if (got_err !== 1'b1 || lat !== 1) begin
            bad++; $display("FAIL illegal_store: got err %b lat %0d want 1 1", got_err, lat);
        end
        total++;
        if (en_cnt - e0 !== 0) begin bad++; $display("FAIL illegal_enable: got %0d want 0", en_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [31:0] first;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wr     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h10;
        @(posedge clk);
        #1;
        req_funct3 = 3'd0;
        req_addr   = 32'h21;
        c     = 0;
        first = 32'h0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid) first = rsp_rdata;
            if (req_ready) begin c = i; break; end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        total++;
        if (c !== 3) begin bad++; $display("FAIL b2b_ready_gap: got %0d want 3", c); end
        total++;
        if (first !== 32'h1234_5678) begin bad++; $display("FAIL b2b_first: got %h want 12345678", first); end
        wait_rsp();
        total++;
        if (got_rdata !== 32'hFFFF_FFDD || lat !== 2) begin
            bad++; $display("FAIL b2b_second: got %h lat %0d want ffffffdd lat 2", got_rdata, lat);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        logic seen;
        for (int i = 0; i < 5; i++) poke(8'h40 + 8'(i), 8'h11);
        issue(1'b1, 3'd2, 32'h41, 32'hAABB_CCDD);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        total++;
        if ({mem_enable, req_ready, rsp_valid} !== 3'b010) begin
            bad++; $display("FAIL rst_mid_outputs: got %b want 010", {mem_enable, req_ready, rsp_valid});
        end
        @(negedge clk);
        rst = 1'b1;
        e0   = en_cnt;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || en_cnt - e0 !== 0) begin
            bad++; $display("FAIL rst_mid_quiet: got rsp %b enables %0d want 0 0", seen, en_cnt - e0);
        end
        total++;
        if ({mem[8'h41], mem[8'h42], mem[8'h43], mem[8'h44]} !== 32'hDDCC_1111) begin
            bad++; $display("FAIL rst_mid_bytes: got %h want ddcc1111",
                            {mem[8'h41], mem[8'h42], mem[8'h43], mem[8'h44]});
        end
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        en_cnt     = 0;
        ns_en_cnt  = 0;
        last_len   = 2'b00;
        pk_en      = 1'b0;
        pk_addr    = 8'h0;
        pk_data    = 8'h0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_aligned_lw();
        test_lb_lbu();
        test_misaligned_sw();
        test_misaligned_lh();
        test_wrap();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
